// File: rtl/reset_seq_pkg.sv
// Shared types for the staged reset sequencer:
// FSM state encoding and reset-cause codes.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        REL,
        RUN
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_SOFT = 2'b01;
    localparam logic [1:0] CAUSE_WDT  = 2'b10;
    localparam logic [1:0] CAUSE_BOTH = 2'b11;

endpackage

// File: rtl/ctech_mux2x1_4.sv
// Behavioural model of the 2:1 mux library cell.
// Ports: i0/i1 data, s select (1 picks i1), z output.
module ctech_mux2x1_4 (
    input  logic i0,
    input  logic i1,
    input  logic s,
    output logic z
);

    assign z = s ? i1 : i0;

endmodule

// File: rtl/reset_seq_ctrl.sv
// Staged reset release for NUM_DOM domains on dclk.
// Ports: dclk, arst_n, scan_mode, soft/wdt requests;
// rst_n_out (bit 0 first), busy, rst_cause.
import reset_seq_pkg::*;

module reset_seq_ctrl #(
    parameter int NUM_DOM    = 3,
    parameter int MIN_ASSERT = 4,
    parameter int STAGE_DLY  = 2
) (
    input  logic               dclk,
    input  logic               arst_n,
    input  logic               scan_mode,
    input  logic               soft_rst_req,
    input  logic               wdt_rst_req,
    output logic [NUM_DOM-1:0] rst_n_out,
    output logic               busy,
    output logic [1:0]         rst_cause
);

    localparam int MAXD =
        (MIN_ASSERT > STAGE_DLY) ? MIN_ASSERT : STAGE_DLY;
    localparam int CW = $clog2(MAXD) + 1;
    localparam int SW = $clog2(NUM_DOM) + 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_ASSERT - 1);
    localparam logic [CW-1:0] REL_LAST  = CW'(STAGE_DLY - 1);
    localparam logic [SW-1:0] LAST_STG  = SW'(NUM_DOM - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SW-1:0]      stage_q, stage_d;
    logic [NUM_DOM-1:0] rst_q, rst_d;
    logic               busy_q, busy_d;
    logic [1:0]         cause_q, cause_d;
    logic               req;

    assign req = soft_rst_req | wdt_rst_req;

    always_ff @(posedge dclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            stage_q <= '0;
            rst_q   <= '0;
            busy_q  <= 1'b1;
            cause_q <= CAUSE_POR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        rst_d   = rst_q;
        busy_d  = busy_q;
        cause_d = cause_q;

        if (req) begin
            // Any request restarts the whole sequence,
            // reasserting domains already released.
            state_d = HOLD;
            cnt_d   = '0;
            stage_d = '0;
            rst_d   = '0;
            busy_d  = 1'b1;
            cause_d = {wdt_rst_req, soft_rst_req};
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        rst_d[0] = 1'b1;
                        cnt_d    = '0;
                        if (NUM_DOM == 1) begin
                            state_d = RUN;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = REL;
                            stage_d = SW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                REL: begin
                    if (cnt_q == REL_LAST) begin
                        // Decode stage without a wide index.
                        for (int i = 0; i < NUM_DOM; i++) begin
                            if (stage_q == SW'(i)) begin
                                rst_d[i] = 1'b1;
                            end
                        end
                        cnt_d   = '0;
                        stage_d = stage_q + SW'(1);
                        if (stage_q == LAST_STG) begin
                            state_d = RUN;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RUN: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end
    end

    // Scan bypass: every output follows arst_n directly.
    for (genvar g = 0; g < NUM_DOM; g++) begin : g_scan
        ctech_mux2x1_4 u_mux (
            .i0 (rst_q[g]),
            .i1 (arst_n),
            .s  (scan_mode),
            .z  (rst_n_out[g])
        );
    end

    assign busy      = busy_q;
    assign rst_cause = cause_q;

endmodule
